// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the two ports of an 8x32 dual-port RAM
// among four requesters, with read tagging and per-requester return.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req/we/addr/wdata   per-requester command (slice i belongs to i)
//   gnt                 one-cycle grant pulse per requester
//   rvalid/rdata        per-requester read return (rdata holds last)
//   ram_*1, ram_*2      registered RAM port commands / RAM read data
module ram_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      rvalid,
  output logic [4*DW-1:0] rdata,
  output logic            ram_wen1,
  output logic            ram_wen2,
  output logic [AW-1:0]   ram_addr1,
  output logic [AW-1:0]   ram_addr2,
  output logic [DW-1:0]   ram_din1,
  output logic [DW-1:0]   ram_din2,
  input  logic [DW-1:0]   ram_dout1,
  input  logic [DW-1:0]   ram_dout2
);

  logic [1:0]      ptr;
  logic [3:0]      elig;
  logic            f1, f2;
  logic [1:0]      w1, w2;
  logic [1:0]      scan;
  logic [3:0]      gnt_nxt;
  logic [1:0]      ptr_nxt;

  // read tag pipeline: s1 rides with the command regs, s2 with ram_dout
  logic            s1_v1, s1_v2, s2_v1, s2_v2;
  logic [1:0]      s1_o1, s1_o2, s2_o1, s2_o2;
  logic [4*DW-1:0] rdata_q;

  // a requester whose grant is showing this cycle sits out
  assign elig = req & ~gnt;

  always_comb begin
    f1   = 1'b0;
    f2   = 1'b0;
    w1   = '0;
    w2   = '0;
    scan = '0;
    for (int j = 0; j < 4; j++) begin
      scan = ptr + 2'(j);
      if (elig[scan]) begin
        if (!f1) begin
          f1 = 1'b1;
          w1 = scan;
        end else if (!f2) begin
          // two writes to one address would race inside the RAM
          if (!(we[w1] && we[scan] &&
                addr[w1*AW +: AW] == addr[scan*AW +: AW])) begin
            f2 = 1'b1;
            w2 = scan;
          end
        end
      end
    end
  end

  always_comb begin
    gnt_nxt = '0;
    if (f1) gnt_nxt[w1] = 1'b1;
    if (f2) gnt_nxt[w2] = 1'b1;
  end

  always_comb begin
    ptr_nxt = ptr;
    if (f2)      ptr_nxt = w2 + 2'd1;
    else if (f1) ptr_nxt = w1 + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      gnt       <= '0;
      ram_wen1  <= 1'b0;
      ram_wen2  <= 1'b0;
      ram_addr1 <= '0;
      ram_addr2 <= '0;
      ram_din1  <= '0;
      ram_din2  <= '0;
      s1_v1     <= 1'b0;
      s1_v2     <= 1'b0;
      s1_o1     <= '0;
      s1_o2     <= '0;
      s2_v1     <= 1'b0;
      s2_v2     <= 1'b0;
      s2_o1     <= '0;
      s2_o2     <= '0;
      rdata_q   <= '0;
    end else begin
      ptr <= ptr_nxt;
      gnt <= gnt_nxt;

      // idle ports issue a harmless read of address 0
      ram_wen1  <= f1 & we[w1];
      ram_addr1 <= f1 ? addr[w1*AW +: AW] : '0;
      ram_din1  <= f1 ? wdata[w1*DW +: DW] : '0;
      ram_wen2  <= f2 & we[w2];
      ram_addr2 <= f2 ? addr[w2*AW +: AW] : '0;
      ram_din2  <= f2 ? wdata[w2*DW +: DW] : '0;

      s1_v1 <= f1 & ~we[w1];
      s1_o1 <= f1 ? w1 : '0;
      s1_v2 <= f2 & ~we[w2];
      s1_o2 <= f2 ? w2 : '0;

      s2_v1 <= s1_v1;
      s2_o1 <= s1_o1;
      s2_v2 <= s1_v2;
      s2_o2 <= s1_o2;

      if (s2_v1) rdata_q[s2_o1*DW +: DW] <= ram_dout1;
      if (s2_v2) rdata_q[s2_o2*DW +: DW] <= ram_dout2;
    end
  end

  // ram_dout is only valid in the s2 cycle, so the return is muxed
  // live and the holding register keeps it afterwards
  always_comb begin
    rvalid = '0;
    rdata  = rdata_q;
    if (s2_v1) begin
      rvalid[s2_o1]           = 1'b1;
      rdata[s2_o1*DW +: DW]   = ram_dout1;
    end
    if (s2_v2) begin
      rvalid[s2_o2]           = 1'b1;
      rdata[s2_o2*DW +: DW]   = ram_dout2;
    end
  end

endmodule
